// File: rtl/key_press_gen.sv
// key_press_gen: pseudo-random synthetic key press generator.
// Rev 1.0 - initial release.
`default_nettype none

module key_press_gen #(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [8:0] threshold,
  output logic       key_out,
  output logic       busy,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Timer counts down to zero, so each phase loads its length minus one.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] timer;
  logic [7:0] timer_nxt;
  logic [9:0] lfsr;
  logic [9:0] lfsr_nxt;
  logic       start;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    start     = 1'b0;
    case (state)
      IDLE: begin
        // Compare uses the pre-advance LFSR value.
        if (enable && (lfsr < {1'b0, threshold})) begin
          start     = 1'b1;
          state_nxt = PRESS;
          timer_nxt = HOLD_LOAD;
        end
      end
      PRESS: begin
        if (timer == 8'd0) begin
          state_nxt = GAP;
          timer_nxt = GAP_LOAD;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      GAP: begin
        if (timer == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = 8'd0;
      end
    endcase
  end

  always_comb begin
    lfsr_nxt = lfsr;
    if (enable) begin
      lfsr_nxt = {lfsr[8:0], ~(lfsr[9] ^ lfsr[6])};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= 8'd0;
      lfsr        <= 10'h000;
      key_out     <= 1'b0;
      busy        <= 1'b0;
      press_count <= 8'd0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      lfsr    <= lfsr_nxt;
      // Outputs are registered from the next state so they align with state.
      key_out <= (state_nxt == PRESS);
      busy    <= (state_nxt != IDLE);
      if (start && (press_count != 8'hFF)) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_press_gen.sv
// tb_key_press_gen: scoreboard bench for key_press_gen.
// Rev 1.0 - initial release.
`default_nettype none

module tb_key_press_gen;

  localparam int HOLD = 2;
  localparam int GAPC = 2;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [8:0] threshold;
  logic       key_out;
  logic       busy;
  logic [7:0] press_count;

  int checks   = 0;
  int failures = 0;

  key_press_gen #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .threshold  (threshold),
    .key_out    (key_out),
    .busy       (busy),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0=idle 1=press 2=gap, left = cycles remaining.
  logic [19:0] exp_q[$];
  logic [9:0]  m_lfsr;
  int          m_phase;
  int          m_left;
  logic [7:0]  m_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr  = 10'h000;
      m_phase = 0;
      m_left  = 0;
      m_cnt   = 8'd0;
      exp_q.delete();
    end else begin
      if (m_phase == 0) begin
        if (enable && ({1'b0, threshold} > m_lfsr)) begin
          m_phase = 1;
          m_left  = HOLD;
          if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
        end
      end else if (m_phase == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_phase = 2;
          m_left  = GAPC;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 0;
      end
      if (enable) m_lfsr = {m_lfsr[8:0], (m_lfsr[9] == m_lfsr[6])};
      exp_q.push_back({(m_phase == 1), (m_phase != 0), m_cnt, m_lfsr});
    end
  end

  logic [19:0] exp;
  logic [19:0] obs;

  // Advance one clock and fetch the expected outputs for that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    obs = {key_out, busy, press_count, dut.lfsr};
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty t=%0t", $time);
      exp = 20'hxxxxx;
    end else begin
      exp = exp_q.pop_front();
    end
  endtask

  task automatic do_reset(input logic en, input logic [8:0] thr);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    enable    = en;
    threshold = thr;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({key_out, busy, press_count} !== 10'd0) begin
      failures++;
      $display("FAIL reset_no_clock got=%h want=000", {key_out, busy, press_count});
    end
    do_reset(1'b0, 9'h1FF);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs !== exp || dut.lfsr !== 10'h000) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_lfsr();
    logic [9:0] seq [4];
    seq[0] = 10'h001; seq[1] = 10'h003; seq[2] = 10'h007; seq[3] = 10'h00F;
    do_reset(1'b1, 9'h000);
    checks++;
    if (dut.lfsr !== 10'h000) begin
      failures++;
      $display("FAIL lfsr_start got=%h want=000", dut.lfsr);
    end
    for (int i = 0; i < 1000; i++) begin
      tick();
      checks++;
      if (obs !== exp || key_out !== 1'b0 || press_count !== 8'd0 ||
          (i < 4 && dut.lfsr !== seq[i])) begin
        failures++;
        $display("FAIL lfsr_walk cyc=%0d got=%h want=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_press_shape();
    logic [1:0] shape [5];
    shape[0] = 2'b11; shape[1] = 2'b11; shape[2] = 2'b01; shape[3] = 2'b01; shape[4] = 2'b00;
    do_reset(1'b1, 9'h1FF);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) enable = 1'b0;
      checks++;
      if (obs !== exp || {key_out, busy} !== shape[i] || press_count !== 8'd1) begin
        failures++;
        $display("FAIL press_shape cyc=%0d got=%h want=%h kb=%b", i, obs, exp, shape[i]);
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [1:0] shape [5];
    shape[0] = 2'b11; shape[1] = 2'b11; shape[2] = 2'b01; shape[3] = 2'b01; shape[4] = 2'b00;
    do_reset(1'b1, 9'h1FF);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (i == 0) enable = 1'b0;
      if (i == 1) threshold = 9'h000;
      checks++;
      if (obs !== exp || press_count !== 8'd1 ||
          (i < 5 && {key_out, busy} !== shape[i]) || (i >= 4 && busy !== 1'b0)) begin
        failures++;
        $display("FAIL enable_drop cyc=%0d got=%h want=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 9'h1FF);
    tick();
    checks++;
    if (obs !== exp || key_out !== 1'b1) begin
      failures++;
      $display("FAIL async_pre got=%h want=%h", obs, exp);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({key_out, busy, press_count} !== 10'd0) begin
      failures++;
      $display("FAIL async_reset got=%h want=000", {key_out, busy, press_count});
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_saturation();
    int hi_len = 0;
    do_reset(1'b1, 9'h1FF);
    for (int i = 0; i < 3000; i++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL saturation cyc=%0d got=%h want=%h", i, obs, exp);
      end
      if (key_out === 1'b1) begin
        hi_len++;
      end else if (hi_len != 0) begin
        checks++;
        if (hi_len != HOLD) begin
          failures++;
          $display("FAIL pulse_width cyc=%0d got=%0d want=%0d", i, hi_len, HOLD);
        end
        hi_len = 0;
      end
    end
    checks++;
    if (press_count !== 8'd255) begin
      failures++;
      $display("FAIL saturate_count got=%0d want=255", press_count);
    end
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    threshold = 9'h000;
    test_reset();
    test_lfsr();
    test_press_shape();
    test_enable_drop();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_press_gen.md
KEY_PRESS_GEN -- requirements
Module: key_press_gen

Interface
REQ-001 Parameter HOLD_CYCLES, default 2, number of clocks key_out is held high per press (legal 1..255).
REQ-002 Parameter GAP_CYCLES, default 2, minimum clocks key_out is held low after each press (legal 1..255).
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately, independent of clk.
REQ-005 Port enable  input  1  1 = generator may start new presses; 0 = no new press starts.
REQ-006 Port threshold  input  9  press probability control; larger value = more frequent presses.
REQ-007 Port key_out  output  1  registered synthetic key level, high during a press; drives a key edge detector.
REQ-008 Port busy  output  1  1 whenever the FSM is not in IDLE.
REQ-009 Port press_count  output  8  number of presses started since reset, saturating.

Function
REQ-010 The block SHALL contain a 10-bit LFSR: next = {lfsr[8:0], ~(lfsr[9] ^ lfsr[6])} (XNOR feedback, all-zero state legal).
REQ-011 The LFSR SHALL advance on every clock edge while enable=1 and hold its value while enable=0, in every FSM state.
REQ-012 The FSM SHALL have exactly three states: IDLE, PRESS, GAP.
REQ-013 IDLE -> PRESS on an edge where enable=1 and lfsr < {1'b0, threshold} (unsigned 10-bit compare, pre-advance LFSR value); otherwise stay in IDLE.
REQ-014 PRESS SHALL last exactly HOLD_CYCLES clocks, then -> GAP.
REQ-015 GAP SHALL last exactly GAP_CYCLES clocks, then -> IDLE.
REQ-016 key_out SHALL be a registered output: 1 exactly in the cycles the FSM is in PRESS, 0 otherwise; no combinational path from inputs.
REQ-017 Latency: key_out SHALL rise on the same edge at which the IDLE->PRESS condition is sampled true.
REQ-018 Each press SHALL therefore produce one clean 0->1->0 level with at least GAP_CYCLES low cycles plus one IDLE cycle before the next rise.
REQ-019 threshold=0 SHALL never start a press.
REQ-020 Deasserting enable during PRESS or GAP SHALL NOT truncate the press or gap; the sequence completes and the FSM then stays in IDLE.
REQ-021 Changes to threshold during PRESS or GAP SHALL have no effect until the FSM is back in IDLE.
REQ-022 press_count SHALL increment by 1 on each IDLE->PRESS transition and saturate at 255 (no wrap).
REQ-023 A single 8-bit down-counter SHALL time PRESS and GAP; it is loaded on each state entry and counts to zero.
REQ-024 busy SHALL equal 1 in PRESS and GAP and 0 in IDLE, registered with the state.

Reset
REQ-025 While reset=0: state=IDLE, key_out=0, busy=0, press_count=0, lfsr=10'h000, timer=0.
REQ-026 Reset assertion mid-PRESS or mid-GAP SHALL force key_out=0 and busy=0 without waiting for a clock edge.
REQ-027 After reset releases, the first legal press start SHALL be on the first rising edge with reset=1, enable=1 and the compare true.

Verification
REQ-028 Reset: reset=0, no clocks -> key_out=0, busy=0, press_count=0; after release with enable=0, LFSR stays at 000 for 10 clocks.
REQ-029 LFSR: enable=1, threshold=0 -> LFSR visits 000, 001, 003, 007, 00F on successive edges; key_out stays 0 for 1000 clocks, press_count=0.
REQ-030 Press shape: threshold=9'h1FF, enable=1 from reset -> key_out high on the first edge (lfsr=000 < 1FF), high exactly 2 clocks, low exactly 2, busy high 4 clocks, press_count=1.
REQ-031 Enable drop: enable->0 in the first PRESS cycle -> key_out still high 2 clocks, GAP 2 clocks, then IDLE with key_out=0 indefinitely, press_count unchanged after.
REQ-032 Async reset: reset->0 between edges during PRESS -> key_out=0, busy=0 immediately; press_count=0.
REQ-033 Saturation: threshold=9'h1FF, enable=1 for more than 2000 clocks -> press_count reaches 255 and holds at 255; every key_out high pulse is exactly HOLD_CYCLES long.
